// File: rtl/aes256_key_sched.sv
// AES-256 key-schedule engine: loads a 256-bit cipher key and generates the
// 15 round keys (one per cycle) into an internal store. SubWord uses an
// external shared combinational S-box; round keys are read back by index
// through a registered read port.
module aes256_key_sched #(
   parameter int NUM_RK = 15
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [255:0] key,
   input  logic         start,
   output logic         busy,
   output logic         key_valid,
   input  logic [3:0]   rd_round,
   output logic [127:0] rd_key,
   output logic [31:0]  sboxw_out,
   input  logic [31:0]  sboxw_in
);

   localparam logic [3:0] LAST_RK = 4'(NUM_RK - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      GEN  = 2'd2,
      DONE = 2'd3
   } state_t;

   state_t        state_r;
   state_t        state_nx_s;
   logic [3:0]    cnt_r;
   logic [7:0]    rcon_r;
   logic [127:0]  prev0_r;
   logic [127:0]  prev1_r;
   logic          busy_r;
   logic          key_valid_r;
   logic [127:0]  rd_key_r;
   logic [127:0]  rk_mem [NUM_RK];

   logic [31:0]   t_s;
   logic [31:0]   k0_s;
   logic [31:0]   k1_s;
   logic [31:0]   k2_s;
   logic [31:0]   k3_s;
   logic [127:0]  new_rk_s;

   // GF(2^8) multiply by x, used to advance the round constant
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   assign busy      = busy_r;
   assign key_valid = key_valid_r;
   assign rd_key    = rd_key_r;
   // The S-box always sees the last word of the newest key; only GEN uses the result
   assign sboxw_out = prev1_r[31:0];

   // Next-state decode for the load/generate/done sequence
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (start) begin
               state_nx_s = LOAD;
            end else begin
               state_nx_s = IDLE;
            end
         end
         LOAD: state_nx_s = GEN;
         GEN: begin
            if (cnt_r == LAST_RK) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = GEN;
            end
         end
         DONE:    state_nx_s = IDLE;
         default: state_nx_s = IDLE;
      endcase
   end

   // Next round key from the two previous keys and the S-box result
   always_comb begin
      t_s = 32'h0;
      if (cnt_r[0] == 1'b0) begin
         t_s = {sboxw_in[23:0], sboxw_in[31:24]} ^ {rcon_r, 24'h0};
      end else begin
         t_s = sboxw_in;
      end
      k0_s     = prev0_r[127:96] ^ t_s;
      k1_s     = prev0_r[95:64]  ^ k0_s;
      k2_s     = prev0_r[63:32]  ^ k1_s;
      k3_s     = prev0_r[31:0]   ^ k2_s;
      new_rk_s = {k0_s, k1_s, k2_s, k3_s};
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Control and shadow-operand registers; the key is captured on the accepted start
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r       <= 4'd0;
         rcon_r      <= 8'h01;
         prev0_r     <= 128'h0;
         prev1_r     <= 128'h0;
         busy_r      <= 1'b0;
         key_valid_r <= 1'b0;
      end else begin
         busy_r <= (state_nx_s != IDLE);
         case (state_r)
            IDLE: begin
               if (start) begin
                  key_valid_r <= 1'b0;
                  rcon_r      <= 8'h01;
                  prev0_r     <= key[255:128];
                  prev1_r     <= key[127:0];
               end
            end
            LOAD: begin
               cnt_r <= 4'd2;
            end
            GEN: begin
               prev0_r <= prev1_r;
               prev1_r <= new_rk_s;
               cnt_r   <= cnt_r + 4'd1;
               if (cnt_r[0] == 1'b0) begin
                  rcon_r <= xtime(rcon_r);
               end
            end
            DONE: begin
               key_valid_r <= 1'b1;
            end
            default: begin
               key_valid_r <= 1'b0;
            end
         endcase
      end
   end

   // Round-key store; contents are hidden by key_valid so no reset is needed
   always_ff @(posedge clk) begin
      if (state_r == LOAD) begin
         rk_mem[0] <= prev0_r;
         rk_mem[1] <= prev1_r;
      end else if (state_r == GEN) begin
         rk_mem[cnt_r] <= new_rk_s;
      end
   end

   // Registered read port; out-of-range index or invalid schedule reads zero
   always_ff @(posedge clk) begin
      if (rst) begin
         rd_key_r <= 128'h0;
      end else if (key_valid_r && (rd_round <= LAST_RK)) begin
         rd_key_r <= rk_mem[rd_round];
      end else begin
         rd_key_r <= 128'h0;
      end
   end

endmodule

// File: tb/tb_aes256_key_sched.sv
// Directed self-checking bench for aes256_key_sched with a behavioural S-box
// and an independent word-based AES-256 key-expansion reference.
module tb_aes256_key_sched;

   logic         clk;
   logic         rst;
   logic [255:0] key;
   logic         start;
   logic         busy;
   logic         key_valid;
   logic [3:0]   rd_round;
   logic [127:0] rd_key;
   logic [31:0]  sboxw_out;
   logic [31:0]  sboxw_in;

   int errors = 0;
   int checks = 0;
   int cyc;
   logic [127:0] exp_rk [15];

   localparam logic [255:0] C3_KEY =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;

   localparam logic [7:0] SBOX [256] = '{
      8'h63,8'h7c,8'h77,8'h7b,8'hf2,8'h6b,8'h6f,8'hc5,8'h30,8'h01,8'h67,8'h2b,8'hfe,8'hd7,8'hab,8'h76,
      8'hca,8'h82,8'hc9,8'h7d,8'hfa,8'h59,8'h47,8'hf0,8'had,8'hd4,8'ha2,8'haf,8'h9c,8'ha4,8'h72,8'hc0,
      8'hb7,8'hfd,8'h93,8'h26,8'h36,8'h3f,8'hf7,8'hcc,8'h34,8'ha5,8'he5,8'hf1,8'h71,8'hd8,8'h31,8'h15,
      8'h04,8'hc7,8'h23,8'hc3,8'h18,8'h96,8'h05,8'h9a,8'h07,8'h12,8'h80,8'he2,8'heb,8'h27,8'hb2,8'h75,
      8'h09,8'h83,8'h2c,8'h1a,8'h1b,8'h6e,8'h5a,8'ha0,8'h52,8'h3b,8'hd6,8'hb3,8'h29,8'he3,8'h2f,8'h84,
      8'h53,8'hd1,8'h00,8'hed,8'h20,8'hfc,8'hb1,8'h5b,8'h6a,8'hcb,8'hbe,8'h39,8'h4a,8'h4c,8'h58,8'hcf,
      8'hd0,8'hef,8'haa,8'hfb,8'h43,8'h4d,8'h33,8'h85,8'h45,8'hf9,8'h02,8'h7f,8'h50,8'h3c,8'h9f,8'ha8,
      8'h51,8'ha3,8'h40,8'h8f,8'h92,8'h9d,8'h38,8'hf5,8'hbc,8'hb6,8'hda,8'h21,8'h10,8'hff,8'hf3,8'hd2,
      8'hcd,8'h0c,8'h13,8'hec,8'h5f,8'h97,8'h44,8'h17,8'hc4,8'ha7,8'h7e,8'h3d,8'h64,8'h5d,8'h19,8'h73,
      8'h60,8'h81,8'h4f,8'hdc,8'h22,8'h2a,8'h90,8'h88,8'h46,8'hee,8'hb8,8'h14,8'hde,8'h5e,8'h0b,8'hdb,
      8'he0,8'h32,8'h3a,8'h0a,8'h49,8'h06,8'h24,8'h5c,8'hc2,8'hd3,8'hac,8'h62,8'h91,8'h95,8'he4,8'h79,
      8'he7,8'hc8,8'h37,8'h6d,8'h8d,8'hd5,8'h4e,8'ha9,8'h6c,8'h56,8'hf4,8'hea,8'h65,8'h7a,8'hae,8'h08,
      8'hba,8'h78,8'h25,8'h2e,8'h1c,8'ha6,8'hb4,8'hc6,8'he8,8'hdd,8'h74,8'h1f,8'h4b,8'hbd,8'h8b,8'h8a,
      8'h70,8'h3e,8'hb5,8'h66,8'h48,8'h03,8'hf6,8'h0e,8'h61,8'h35,8'h57,8'hb9,8'h86,8'hc1,8'h1d,8'h9e,
      8'he1,8'hf8,8'h98,8'h11,8'h69,8'hd9,8'h8e,8'h94,8'h9b,8'h1e,8'h87,8'he9,8'hce,8'h55,8'h28,8'hdf,
      8'h8c,8'ha1,8'h89,8'h0d,8'hbf,8'he6,8'h42,8'h68,8'h41,8'h99,8'h2d,8'h0f,8'hb0,8'h54,8'hbb,8'h16
   };

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   assign sboxw_in = sub_word(sboxw_out);

   aes256_key_sched #(.NUM_RK(15)) dut (
      .clk       (clk),
      .rst       (rst),
      .key       (key),
      .start     (start),
      .busy      (busy),
      .key_valid (key_valid),
      .rd_round  (rd_round),
      .rd_key    (rd_key),
      .sboxw_out (sboxw_out),
      .sboxw_in  (sboxw_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Textbook word-oriented AES-256 key expansion
   task automatic build_model(input logic [255:0] k);
      logic [31:0] w [60];
      logic [31:0] tmp;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 8; i++) w[i] = k[255 - 32*i -: 32];
      for (int i = 8; i < 60; i++) begin
         tmp = w[i-1];
         if (i % 8 == 0) begin
            tmp = sub_word({tmp[23:0], tmp[31:24]}) ^ {rc, 24'h0};
            rc  = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (i % 8 == 4) begin
            tmp = sub_word(tmp);
         end
         w[i] = w[i-8] ^ tmp;
      end
      for (int r = 0; r < 15; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic rd(input logic [3:0] idx, input logic [127:0] exp, input string tag);
      rd_round = idx;
      @(negedge clk);
      chk(tag, rd_key, exp);
   endtask

   task automatic check_all(input string tag);
      for (int r = 0; r < 15; r++) rd(4'(r), exp_rk[r], $sformatf("%s_rk%0d", tag, r));
   endtask

   // Pulse start, optionally re-pulse it mid-run, and count cycles until key_valid
   task automatic run(input logic [255:0] k, input int restart_at, input bit mon_sbox,
                      output int cycles);
      int n;
      key   = k;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      n     = 0;
      chk("kv_clear_on_start", {127'h0, key_valid}, 128'h0);
      chk("busy_after_start", {127'h0, busy}, 128'h1);
      while (key_valid !== 1'b1 && n < 40) begin
         if (n == restart_at) start = 1'b1;
         @(negedge clk);
         start = 1'b0;
         n++;
         if (mon_sbox && n == 1) chk("sboxw_out_r2", {96'h0, sboxw_out}, {96'h0, 32'h1c1d1e1f});
         if (mon_sbox && n == 2) chk("sboxw_out_r3", {96'h0, sboxw_out}, {96'h0, 32'ha572c09c});
      end
      chk("latency", 128'(n), 128'd15);
      chk("busy_after_done", {127'h0, busy}, 128'h0);
      cycles = n;
   endtask

   initial begin
      rst      = 1'b1;
      start    = 1'b0;
      key      = 256'h0;
      rd_round = 4'd0;
      repeat (3) @(negedge clk);
      chk("rst_busy", {127'h0, busy}, 128'h0);
      chk("rst_kv", {127'h0, key_valid}, 128'h0);
      chk("rst_rdkey", rd_key, 128'h0);
      rst = 1'b0;

      // Reads before any run return zero
      rd(4'd0, 128'h0, "pre_rd0");
      rd(4'd15, 128'h0, "pre_rd15");
      chk("pre_kv", {127'h0, key_valid}, 128'h0);

      // Single C.3 run with S-box word monitoring
      build_model(C3_KEY);
      run(C3_KEY, -1, 1'b1, cyc);
      rd(4'd0, 128'h000102030405060708090a0b0c0d0e0f, "c3_rk0");
      rd(4'd1, 128'h101112131415161718191a1b1c1d1e1f, "c3_rk1");
      rd(4'd2, 128'ha573c29fa176c498a97fce93a572c09c, "c3_rk2");
      rd_round = 4'd14;
      #1;
      chk("rd_latency_hold", rd_key, 128'ha573c29fa176c498a97fce93a572c09c);
      @(negedge clk);
      chk("c3_rk14", rd_key, 128'h24fc79ccbf0979e9371ac23c6d68de36);
      check_all("c3");
      rd(4'd15, 128'h0, "c3_rd15");
      chk("kv_sticky", {127'h0, key_valid}, 128'h1);

      // Second start 5 cycles into a run is ignored
      run(C3_KEY, 5, 1'b0, cyc);
      check_all("restart");

      // Reset during GEN r=7 aborts the run
      key   = C3_KEY;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (6) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", {127'h0, busy}, 128'h0);
      chk("abort_kv", {127'h0, key_valid}, 128'h0);
      chk("abort_rdkey", rd_key, 128'h0);
      run(C3_KEY, -1, 1'b0, cyc);
      check_all("after_abort");

      // Back-to-back run with an all-zero key
      build_model(256'h0);
      run(256'h0, -1, 1'b0, cyc);
      rd(4'd2, 128'h62636363626363636263636362636363, "zero_rk2");
      rd(4'd3, 128'haafbfbfbaafbfbfbaafbfbfbaafbfbfb, "zero_rk3");
      check_all("zero");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
